// File: rtl/conv1d_cmd_sequencer.sv
// Runs one conv1d CFU output-point job: config writes, buffer loads, start, poll, read-back.
// Latency: all outputs registered; one CFU command per cycle, ret sampled one cycle after its command.
// Backpressure: data words taken only on data_valid&&data_ready; result held until res_ready.
module conv1d_cmd_sequencer #(
  parameter int INT32_SIZE         = 32,
  parameter int KERNEL_LENGTH      = 8,
  parameter int MAX_INPUT_CHANNELS = 128,
  parameter int POLL_LIMIT         = 4096,
  parameter int IDLE_CMD           = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [7:0]              job_depth,
  input  logic                    job_load_filter,
  input  logic [INT32_SIZE-1:0]   job_input_offset,
  input  logic [INT32_SIZE-1:0]   job_start_x,
  input  logic [6*INT32_SIZE-1:0] job_quant,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [INT32_SIZE-1:0]   data_word,
  output logic [6:0]              cmd,
  output logic [INT32_SIZE-1:0]   inp0,
  output logic [INT32_SIZE-1:0]   inp1,
  input  logic [INT32_SIZE-1:0]   ret,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [INT32_SIZE-1:0]   res_data,
  output logic                    timeout
);

  localparam int WCW = $clog2(KERNEL_LENGTH * MAX_INPUT_CHANNELS / 4 + 1);
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [6:0] C_IDLE = 7'(IDLE_CMD);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_LOADF, S_LOADI, S_START, S_GAP,
    S_PISS, S_PWAIT, S_PCHK, S_RWAIT, S_RCAP, S_OUT
  } state_t;

  state_t                  state, state_n;
  logic [6:0]              cmd_n;
  logic [INT32_SIZE-1:0]   inp0_n, inp1_n, res_data_n;
  logic                    job_ready_n, data_ready_n, res_valid_n, timeout_n;
  logic [3:0]              cfg_idx, cfg_idx_n;
  logic [WCW-1:0]          word_cnt, word_cnt_n, word_total, word_total_n;
  logic [PCW-1:0]          poll_cnt, poll_cnt_n;
  logic [7:0]              lat_depth, lat_depth_n;
  logic                    lat_lf, lat_lf_n;
  logic [INT32_SIZE-1:0]   lat_off, lat_off_n, lat_sx, lat_sx_n;
  logic [6*INT32_SIZE-1:0] lat_quant, lat_quant_n;
  logic                    handshake, last_word;

  // State and every registered output; reset aborts any job back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= C_IDLE;
      inp0       <= '0;
      inp1       <= '0;
      job_ready  <= 1'b1;
      data_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      timeout    <= 1'b0;
      cfg_idx    <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      poll_cnt   <= '0;
      lat_depth  <= '0;
      lat_lf     <= 1'b0;
      lat_off    <= '0;
      lat_sx     <= '0;
      lat_quant  <= '0;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      inp0       <= inp0_n;
      inp1       <= inp1_n;
      job_ready  <= job_ready_n;
      data_ready <= data_ready_n;
      res_valid  <= res_valid_n;
      res_data   <= res_data_n;
      timeout    <= timeout_n;
      cfg_idx    <= cfg_idx_n;
      word_cnt   <= word_cnt_n;
      word_total <= word_total_n;
      poll_cnt   <= poll_cnt_n;
      lat_depth  <= lat_depth_n;
      lat_lf     <= lat_lf_n;
      lat_off    <= lat_off_n;
      lat_sx     <= lat_sx_n;
      lat_quant  <= lat_quant_n;
    end
  end

  // Next state and the command to present on the following cycle.
  always_comb begin
    state_n      = state;
    cmd_n        = C_IDLE;
    inp0_n       = '0;
    inp1_n       = '0;
    job_ready_n  = 1'b0;
    data_ready_n = 1'b0;
    res_valid_n  = res_valid;
    res_data_n   = res_data;
    timeout_n    = timeout;
    cfg_idx_n    = cfg_idx;
    word_cnt_n   = word_cnt;
    word_total_n = word_total;
    poll_cnt_n   = poll_cnt;
    lat_depth_n  = lat_depth;
    lat_lf_n     = lat_lf;
    lat_off_n    = lat_off;
    lat_sx_n     = lat_sx;
    lat_quant_n  = lat_quant;
    handshake    = data_valid && data_ready;
    last_word    = (word_cnt == word_total - 1'b1);
    case (state)
      S_IDLE: begin
        job_ready_n = 1'b1;
        if (job_valid && job_ready) begin
          job_ready_n  = 1'b0;
          timeout_n    = 1'b0;
          lat_depth_n  = job_depth;
          lat_lf_n     = job_load_filter;
          lat_off_n    = job_input_offset;
          lat_sx_n     = job_start_x;
          lat_quant_n  = job_quant;
          word_total_n = WCW'((KERNEL_LENGTH * int'(job_depth)) / 4);
          cfg_idx_n    = '0;
          if (job_depth == 8'd0 || int'(job_depth) > MAX_INPUT_CHANNELS) begin
            // Out-of-range depth: report an empty result without touching the CFU.
            res_valid_n = 1'b1;
            res_data_n  = '0;
            state_n     = S_OUT;
          end else begin
            state_n = S_CFG;
          end
        end
      end
      S_CFG: begin
        case (cfg_idx)
          4'd0:    begin cmd_n = 7'd18; inp1_n = INT32_SIZE'(4); end
          4'd1:    begin cmd_n = 7'd3;  inp1_n = lat_off; end
          4'd2:    begin cmd_n = 7'd5;  inp1_n = INT32_SIZE'(lat_depth); end
          4'd3:    begin cmd_n = 7'd8;  inp1_n = lat_sx; end
          4'd4:    begin cmd_n = 7'd12; inp1_n = lat_quant[0*INT32_SIZE +: INT32_SIZE]; end
          4'd5:    begin cmd_n = 7'd13; inp1_n = lat_quant[1*INT32_SIZE +: INT32_SIZE]; end
          4'd6:    begin cmd_n = 7'd14; inp1_n = lat_quant[2*INT32_SIZE +: INT32_SIZE]; end
          4'd7:    begin cmd_n = 7'd15; inp1_n = lat_quant[3*INT32_SIZE +: INT32_SIZE]; end
          4'd8:    begin cmd_n = 7'd16; inp1_n = lat_quant[4*INT32_SIZE +: INT32_SIZE]; end
          default: begin cmd_n = 7'd17; inp1_n = lat_quant[5*INT32_SIZE +: INT32_SIZE]; end
        endcase
        cfg_idx_n = cfg_idx + 4'd1;
        if (cfg_idx == 4'd9) begin
          word_cnt_n   = '0;
          data_ready_n = 1'b1;
          state_n      = lat_lf ? S_LOADF : S_LOADI;
        end
      end
      S_LOADF, S_LOADI: begin
        data_ready_n = 1'b1;
        if (handshake) begin
          cmd_n      = (state == S_LOADF) ? 7'd2 : 7'd1;
          inp0_n     = INT32_SIZE'({word_cnt, 2'b00});
          inp1_n     = data_word;
          word_cnt_n = word_cnt + 1'b1;
          if (last_word) begin
            word_cnt_n = '0;
            if (state == S_LOADF) begin
              state_n = S_LOADI;
            end else begin
              data_ready_n = 1'b0;
              state_n      = S_START;
            end
          end
        end
      end
      S_START: begin
        cmd_n      = 7'd6;
        poll_cnt_n = '0;
        state_n    = S_GAP;
      end
      S_GAP:   state_n = S_PISS;
      S_PISS: begin
        cmd_n      = 7'd9;
        poll_cnt_n = poll_cnt + 1'b1;
        state_n    = S_PWAIT;
      end
      S_PWAIT: state_n = S_PCHK;
      S_PCHK: begin
        // ret here is the response to the poll issued two cycles ago.
        if (ret[0]) begin
          cmd_n   = 7'd7;
          state_n = S_RWAIT;
        end else if (poll_cnt == PCW'(POLL_LIMIT)) begin
          timeout_n   = 1'b1;
          res_data_n  = '0;
          res_valid_n = 1'b1;
          state_n     = S_OUT;
        end else begin
          cmd_n      = 7'd9;
          poll_cnt_n = poll_cnt + 1'b1;
          state_n    = S_PWAIT;
        end
      end
      S_RWAIT: state_n = S_RCAP;
      S_RCAP: begin
        res_data_n  = ret;
        res_valid_n = 1'b1;
        state_n     = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          job_ready_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Bench for conv1d_cmd_sequencer: a CFU stub answers commands, a job-level model predicts
// the exact command stream and result, and a per-cycle monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_conv1d_cmd_sequencer;
  localparam int PL   = 16;
  localparam int IDLE = 19;

  typedef logic [31:0] warr_t [256];
  typedef struct { logic [6:0] c; logic [31:0] a; logic [31:0] v; bit chk; } exp_t;

  logic         clk = 0, rst = 0;
  logic         job_valid = 0, job_ready, job_load_filter = 0;
  logic [7:0]   job_depth = 0;
  logic [31:0]  job_input_offset = 0, job_start_x = 0;
  logic [191:0] job_quant = 0;
  logic         data_valid = 0, data_ready;
  logic [31:0]  data_word = 0;
  logic [6:0]   cmd;
  logic [31:0]  inp0, inp1, ret = 0;
  logic         res_valid, res_ready = 0;
  logic [31:0]  res_data;
  logic         timeout;

  conv1d_cmd_sequencer #(.POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_depth(job_depth), .job_load_filter(job_load_filter),
    .job_input_offset(job_input_offset), .job_start_x(job_start_x), .job_quant(job_quant),
    .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
    .cmd(cmd), .inp0(inp0), .inp1(inp1), .ret(ret),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  exp_t exp_q[$];
  logic [31:0] src_q[$];
  warr_t fbuf, ibuf, model_filter, model_input;
  int s_off = 0, s_depth = 0, s_bias = 0, s_polls = 0, done_after = 1;
  logic hs_last = 0, rr_last = 0;
  logic [6:0] prev_cmd = 7'(IDLE);
  logic prev_rv = 0;
  logic [31:0] prev_rd = 0, last_res = 0;
  logic last_to = 0;
  int cnt1, cnt2, cnt6, cnt9, cnt_any;

  // Dot product of the two buffers with offset and bias: the CFU result under identity quant.
  function automatic int dot(input warr_t f, input warr_t x, input int w, input int off, input int bias);
    int acc;
    logic signed [7:0] fb, xb;
    acc = bias;
    for (int a = 0; a < w; a++)
      for (int b = 0; b < 4; b++) begin
        fb = f[a][8*b +: 8];
        xb = x[a][8*b +: 8];
        acc += int'(fb) * (int'(xb) + off);
      end
    return acc;
  endfunction

  // CFU stub: registered response one cycle after each command.
  always @(posedge clk) begin
    case (cmd)
      7'd1:  begin ibuf[inp0[9:2]] <= inp1; ret <= 0; end
      7'd2:  begin fbuf[inp0[9:2]] <= inp1; ret <= 0; end
      7'd3:  begin s_off <= int'(inp1); ret <= 0; end
      7'd5:  begin s_depth <= int'(inp1); ret <= 0; end
      7'd12: begin s_bias <= int'(inp1); ret <= 0; end
      7'd6:  begin s_polls <= 0; ret <= 0; end
      7'd9:  begin s_polls <= s_polls + 1; ret <= (s_polls + 1 >= done_after) ? 32'd1 : 32'd0; end
      7'd7:  ret <= dot(fbuf, ibuf, s_depth * 2, s_off, s_bias);
      default: ret <= 0;
    endcase
  end

  always @(posedge clk) begin
    hs_last <= data_valid && data_ready;
    rr_last <= res_valid && res_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, expv);
    end
  endtask

  task automatic push(input int c, input int a, input logic [31:0] v, input bit chk);
    exp_t e;
    e.c = 7'(c); e.a = 32'(a); e.v = v; e.chk = chk;
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison of the DUT against the predicted command stream.
  task automatic mon();
    exp_t e;
    if (rst) begin prev_cmd = 7'(IDLE); prev_rv = 0; return; end
    check("load_iff_handshake", 32'(cmd == 7'd1 || cmd == 7'd2), 32'(hs_last));
    if (prev_cmd == 7'd6 || prev_cmd == 7'd9 || prev_cmd == 7'd7)
      check("idle_after_single", 32'(cmd), 32'(IDLE));
    if (cmd != 7'(IDLE)) begin
      cnt_any++;
      if (cmd == 7'd1) cnt1++;
      if (cmd == 7'd2) cnt2++;
      if (cmd == 7'd6) cnt6++;
      if (cmd == 7'd9) cnt9++;
      if (exp_q.size() == 0) check("cmd_unexpected", 32'(cmd), 32'(IDLE));
      else begin
        e = exp_q.pop_front();
        check("cmd_seq", 32'(cmd), 32'(e.c));
        if (e.chk) begin
          check("inp0_seq", inp0, e.a);
          check("inp1_seq", inp1, e.v);
        end
      end
    end
    if (prev_rv && !rr_last) begin
      check("res_valid_hold", 32'(res_valid), 32'd1);
      check("res_data_hold", res_data, prev_rd);
    end
    prev_cmd = cmd; prev_rv = res_valid; prev_rd = res_data;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"}, 32'(cmd), 32'(IDLE));
    check({tag, "_inp0"}, inp0, 32'd0);
    check({tag, "_inp1"}, inp1, 32'd0);
    check({tag, "_job_ready"}, 32'(job_ready), 32'd1);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // Data source: pops a word after each observed handshake. mode 0 always valid, 1 = 1,0,0 pattern, 2 random.
  task automatic feeder(input int mode);
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clk);
      if (hs_last) void'(src_q.pop_front());
      if (src_q.size() == 0) break;
      case (mode)
        0:       data_valid = 1'b1;
        1:       data_valid = (k % 3 == 1);
        default: data_valid = 1'($urandom_range(0, 1));
      endcase
      data_word = src_q[0];
    end
    data_valid = 1'b0;
  endtask

  task automatic run_job(input int depth, input bit lf, input int mode, input int da,
                         input bit ones, input int hold, input bit do_reset);
    int w, cyc, limit;
    bit legal, to;
    logic [31:0] off, sx, wd, er;
    logic [191:0] q;
    legal = depth >= 1 && depth <= 128;
    w = depth * 2;
    off = ones ? 32'd0 : 32'($urandom_range(0, 16)) - 32'd8;
    sx = $urandom;
    q = ones ? {32'd0, 32'd127, 32'hFFFF_FF80, 32'd0, 32'd1, 32'd0}
             : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    exp_q.delete();
    cnt1 = 0; cnt2 = 0; cnt6 = 0; cnt9 = 0; cnt_any = 0;
    done_after = da;
    to = 0; er = 0;
    if (legal) begin
      push(18, 0, 32'd4, 1); push(3, 0, off, 1); push(5, 0, 32'(depth), 1); push(8, 0, sx, 1);
      for (int i = 0; i < 6; i++) push(12 + i, 0, q[32*i +: 32], 1);
      if (lf) for (int i = 0; i < w; i++) begin
        wd = ones ? 32'h0101_0101 : $urandom;
        model_filter[i] = wd; src_q.push_back(wd); push(2, 4*i, wd, 1);
      end
      for (int i = 0; i < w; i++) begin
        wd = ones ? 32'h0101_0101 : $urandom;
        model_input[i] = wd; src_q.push_back(wd); push(1, 4*i, wd, 1);
      end
      push(6, 0, 0, 0);
      for (int i = 0; i < ((da <= PL) ? da : PL); i++) push(9, 0, 0, 0);
      if (da <= PL) push(7, 0, 0, 0);
      to = (da > PL);
      er = to ? 32'd0 : 32'(dot(model_filter, model_input, w, int'(off), int'(q[31:0])));
    end
    fork feeder(mode); join_none
    cyc = 0;
    @(negedge clk);
    while (!job_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("job_ready_before_accept", 32'(job_ready), 32'd1);
    job_valid = 1; job_depth = 8'(depth); job_load_filter = lf;
    job_input_offset = off; job_start_x = sx; job_quant = q;
    @(posedge clk);
    @(negedge clk);
    job_valid = 0;
    check("timeout_cleared_on_accept", 32'(timeout), 32'd0);
    if (do_reset) begin
      cyc = 0;
      while (cmd != 7'd9 && cyc < 2000) begin @(negedge clk); cyc++; end
      check("reached_poll", 32'(cmd), 32'd9);
      #2 rst = 1;
      #1 check_reset("mid_poll_reset");
      exp_q.delete(); src_q.delete();
      @(negedge clk); @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("job_ready_after_reset", 32'(job_ready), 32'd1);
      return;
    end
    limit = legal ? 5000 : 3;
    cyc = 1;
    while (!res_valid && cyc < limit) begin @(negedge clk); cyc++; end
    check("res_valid_within_bound", 32'(res_valid), 32'd1);
    check("res_data", res_data, er);
    check("timeout_flag", 32'(timeout), 32'(to));
    last_res = res_data; last_to = timeout;
    for (int i = 0; i < hold; i++) @(negedge clk);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    check("res_valid_dropped", 32'(res_valid), 32'd0);
    check("job_ready_after_out", 32'(job_ready), 32'd1);
    check("expected_cmds_consumed", 32'(exp_q.size()), 32'd0);
    check("source_drained", 32'(src_q.size()), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin model_filter[i] = 0; model_input[i] = 0; end
    fork forever begin @(negedge clk); mon(); end join_none
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 0;

    // Full job, all-ones data, identity quant: 32 taps of 1*1.
    run_job(4, 1, 0, 3, 1, 5, 0);
    check("A_result_literal", last_res, 32'd32);
    check("A_cmd2_count", 32'(cnt2), 32'd8);
    check("A_cmd1_count", 32'(cnt1), 32'd8);
    check("A_cmd6_count", 32'(cnt6), 32'd1);
    check("A_cmd9_count", 32'(cnt9), 32'd3);

    // Resident weights.
    run_job(2, 0, 2, 1, 0, 0, 0);
    check("B_cmd2_count", 32'(cnt2), 32'd0);
    check("B_cmd1_count", 32'(cnt1), 32'd4);

    // Stalled source.
    run_job(5, 1, 1, 5, 0, 2, 0);
    check("C_cmd1_count", 32'(cnt1), 32'd10);

    // Poll timeout.
    run_job(1, 1, 0, 1000, 0, 5, 0);
    check("D_cmd9_count", 32'(cnt9), 32'd16);
    check("D_timeout_literal", 32'(last_to), 32'd1);
    check("D_res_zero_literal", last_res, 32'd0);

    // Illegal depths: nothing sent to the CFU.
    run_job(0, 1, 0, 1, 0, 1, 0);
    check("E_no_cmds", 32'(cnt_any), 32'd0);
    run_job(200, 1, 0, 1, 0, 0, 0);
    check("F_no_cmds", 32'(cnt_any), 32'd0);

    // Reset during polling, then a normal job.
    run_job(3, 1, 0, 8, 0, 0, 1);
    run_job(3, 1, 2, 2, 0, 1, 0);

    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 128), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              $urandom_range(1, 20), 0, $urandom_range(0, 4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv1d_cmd_sequencer.md
Name: conv1d_cmd_sequencer

Overview:
- Initiator-side sequencer for the conv1d CFU command protocol: drives `cmd`/`inp0`/`inp1` and samples `ret`.
- Runs one full output-point job without CPU involvement:
  - issues configuration and quant-parameter writes;
  - streams packed weight and input words into the CFU buffers;
  - starts the computation, polls for completion and reads back the quantised result.
- Sits between a job/data source (DMA or CPU-side FIFO) and the conv1d CFU.

Parameters:
- INT32_SIZE, 32, data/command word width
- KERNEL_LENGTH, 8, taps per channel; must match the CFU
- MAX_INPUT_CHANNELS, 128, largest legal job_depth
- POLL_LIMIT, 4096, poll cycles before timeout
- IDLE_CMD, 19, no-op command code; the responder answers it with ret=0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_depth  in  8  input channels, 1..MAX_INPUT_CHANNELS
- job_load_filter  in  1  1 = reload weights; 0 = weights already resident
- job_input_offset  in  32  value for cmd 3
- job_start_x  in  32  value for cmd 8
- job_quant  in  192  {output_offset, act_max, act_min, shift, multiplier, bias}, 32 bits each, bias in LSBs
- data_valid  in  1  packed data word available
- data_ready  out  1  word consumed this cycle
- data_word  in  32  four int8 values, byte0 = lowest address
- cmd  out  7  CFU command
- inp0  out  32  CFU address operand
- inp1  out  32  CFU value operand
- ret  in  32  CFU registered response (one-cycle latency)
- res_valid  out  1  result available
- res_ready  in  1  result accepted
- res_data  out  32  quantised accumulator
- timeout  out  1  sticky error flag; cleared by next job accept

Behaviour:
- Reset values:
  - state=IDLE; cmd=IDLE_CMD; inp0=inp1=0;
  - job_ready=1; data_ready=0; res_valid=0; res_data=0; timeout=0.
- All outputs are registered. Mid-job reset aborts immediately to IDLE with reset values.
- Job accept: handshake when job_valid && job_ready. Latch all job fields; clear timeout. A depth of 0 or greater than MAX_INPUT_CHANNELS is accepted and completes directly with res_data=0 and timeout=0; no CFU commands are issued.
- CFG state: issues one command per cycle, in this order:
  - 18 (inp1=4)
  - 3 (input_offset)
  - 5 (depth)
  - 8 (start_x)
  - 12..17 (bias, mult, shift, min, max, out_offset)
  
  Total 10 cycles. inp0=0 throughout.
- Buffer loads:
  - Word count W = KERNEL_LENGTH*depth/4.
  - LOAD_FILTER (only if job_load_filter): issues W words with cmd=2.
  - LOAD_INPUT: issues W words with cmd=1.
  - Per state, inp0 starts at 0 and increments by 4 per issued word.
- Load handshake:
  - A word is issued in the cycle data_valid && data_ready: cmd=1/2 and inp1=data_word register in the following cycle.
  - data_ready is high in LOAD states while words remain.
  - When data_valid=0, cmd=IDLE_CMD, so no write occurs.
  - Each word is written exactly once.
- START: exactly one cycle of cmd=6, then IDLE_CMD.
  - cmd 6 must never be repeated, because it restarts the computation.
- POLL loop:
  - Issue cmd=9 for one cycle, then IDLE_CMD for one cycle.
  - Sample ret on that second cycle. ret[0]=1 means done; otherwise repeat.
  - A poll counter counts poll issues. On reaching POLL_LIMIT: set timeout, res_data=0, go to OUT.
- READ: issue cmd=7 for one cycle, IDLE_CMD the next cycle, then capture ret into res_data.
- OUT:
  - res_valid=1 until res_ready.
  - res_data is held stable while res_valid=1.
  - On the handshake: return to IDLE with job_ready=1 the next cycle.
  - res_ready while res_valid=0 is ignored.
- In every state not listed above, cmd=IDLE_CMD.

Test Plan:
- Full job:
  - Stimulus: depth=4, load_filter=1, data_valid held high.
  - Required response: 10 CFG cmds; 8 cmd-2 words (inp0 0..28); 8 cmd-1 words; one cmd 6; polls; cmd 7; res_data equals the CFU model result for all-ones data, offset 0, identity quant.
- Resident weights:
  - Stimulus: depth=2, load_filter=0.
  - Required response: no cmd 2 issued; exactly 4 cmd-1 words; inp0 = 0, 4, 8, 12.
- Data stall:
  - Stimulus: data_valid toggled 1,0,0,1,... during LOAD_INPUT.
  - Required response: cmd=IDLE_CMD on stall cycles; the word sequence written to the CFU matches the source order exactly, with no duplicates.
- Timeout:
  - Stimulus: stub CFU returns ret=0 to all cmd 9, POLL_LIMIT=16.
  - Required response: exactly 16 cmd-9 issues, then timeout=1, res_valid=1, res_data=0. The next job accept clears timeout.
- Backpressure and reset:
  - Stimulus: hold res_ready=0 for 5 cycles.
  - Required response: res_valid and res_data stable throughout.
  - Stimulus: assert rst during POLL.
  - Required response: outputs return to reset values asynchronously; the next job runs normally.
- Illegal depth:
  - Stimulus: depth=0.
  - Required response: no CFU commands other than IDLE_CMD; res_valid within 3 cycles; res_data=0.
